// File: rtl/usb_tx_sequencer.sv
// USB packet transmit sequencer: SYNC, LSB-first bit-stuffed data, then EOP,
// driving the NRZI encoder inputs and the SE0 line override.
module usb_tx_sequencer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       enc_en,
    output logic       enc_bit,
    output logic       se0,
    output logic       busy,
    output logic       underrun
);

    localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        STUFF,
        EOP_SE0,
        EOP_J
    } state_t;

    state_t      state;
    logic [DW-1:0] div;
    logic [2:0]  idx;
    logic [2:0]  ones;
    logic [7:0]  byte_q;
    logic        last_q;

    logic        slot_end;
    logic [2:0]  ones_next;
    logic [2:0]  idx_inc;
    logic        stuff_due;
    logic        byte_boundary;
    logic        need_byte;

    // Handshake: tx_ready is a single-cycle request in the last clk of the slot
    // before the next byte's first data slot; the byte transfers when
    // tx_valid && tx_ready. A request met with tx_valid=0 is an underrun and
    // ends the packet. tx_valid never has to wait for tx_ready to rise.
    always_comb begin
        slot_end      = (div == DIV_MAX);
        ones_next     = enc_bit ? (ones + 3'd1) : 3'd0;
        idx_inc       = idx + 3'd1;
        stuff_due     = ((state == SYNC) || (state == DATA)) && (ones_next == 3'd6);
        byte_boundary = slot_end &&
                        (((state == SYNC)  && (idx == 3'd7)) ||
                         ((state == DATA)  && (idx == 3'd7) && !stuff_due) ||
                         ((state == STUFF) && (idx == 3'd7)));
        need_byte     = byte_boundary && ((state == SYNC) || !last_q);
        tx_ready      = need_byte && !RST;
        underrun      = need_byte && !tx_valid && !RST;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state   <= IDLE;
            div     <= '0;
            idx     <= 3'd0;
            ones    <= 3'd0;
            byte_q  <= 8'h00;
            last_q  <= 1'b0;
            enc_en  <= 1'b0;
            enc_bit <= 1'b1;
            se0     <= 1'b0;
            busy    <= 1'b0;
        end else if (state == IDLE) begin
            div <= '0;
            if (tx_valid) begin
                state   <= SYNC;
                idx     <= 3'd0;
                ones    <= 3'd0;
                last_q  <= 1'b0;
                enc_en  <= 1'b1;
                enc_bit <= 1'b0;
                busy    <= 1'b1;
            end
        end else begin
            div <= slot_end ? '0 : (div + DW'(1));
            if (slot_end) begin
                ones <= ones_next;
                if (need_byte) begin
                    if (tx_valid) begin
                        byte_q  <= tx_data;
                        last_q  <= tx_last;
                        state   <= DATA;
                        idx     <= 3'd0;
                        enc_bit <= tx_data[0];
                    end else begin
                        state   <= EOP_SE0;
                        idx     <= 3'd0;
                        enc_en  <= 1'b0;
                        enc_bit <= 1'b1;
                        se0     <= 1'b1;
                    end
                end else begin
                    case (state)
                        SYNC: begin
                            idx     <= idx_inc;
                            enc_bit <= (idx == 3'd6);
                        end
                        DATA: begin
                            if (stuff_due) begin
                                // idx keeps the last data bit so the stream resumes after it
                                state   <= STUFF;
                                enc_bit <= 1'b0;
                            end else if (idx != 3'd7) begin
                                idx     <= idx_inc;
                                enc_bit <= byte_q[idx_inc];
                            end else begin
                                state   <= EOP_SE0;
                                idx     <= 3'd0;
                                enc_en  <= 1'b0;
                                enc_bit <= 1'b1;
                                se0     <= 1'b1;
                            end
                        end
                        STUFF: begin
                            if (idx != 3'd7) begin
                                state   <= DATA;
                                idx     <= idx_inc;
                                enc_bit <= byte_q[idx_inc];
                            end else begin
                                state   <= EOP_SE0;
                                idx     <= 3'd0;
                                enc_en  <= 1'b0;
                                enc_bit <= 1'b1;
                                se0     <= 1'b1;
                            end
                        end
                        EOP_SE0: begin
                            if (idx == 3'd0) begin
                                idx <= 3'd1;
                            end else begin
                                state <= EOP_J;
                                se0   <= 1'b0;
                            end
                        end
                        EOP_J: begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            enc_bit <= 1'b1;
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Self-checking bench for usb_tx_sequencer at CLKS_PER_BIT=1 and 4, with a
// slot-list reference model feeding a per-cycle expected queue.
module tb_usb_tx_sequencer;

    logic       clk;
    logic       RST;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       sel;

    logic rdy0, en0, bit0, se00, busy0, ur0;
    logic rdy1, en1, bit1, se01, busy1, ur1;
    logic v0, v1;
    logic rdy_m, busy_m;
    logic [5:0] out_m;

    int checks;
    int failures;
    int cyc;
    bit mon_en;
    bit chk_idle;

    logic [5:0] exp_q[$];
    logic [7:0] pq[$];

    assign v0 = tx_valid & ~sel;
    assign v1 = tx_valid & sel;

    usb_tx_sequencer #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .RST(RST), .tx_valid(v0), .tx_data(tx_data), .tx_last(tx_last),
        .tx_ready(rdy0), .enc_en(en0), .enc_bit(bit0), .se0(se00), .busy(busy0),
        .underrun(ur0)
    );

    usb_tx_sequencer #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .RST(RST), .tx_valid(v1), .tx_data(tx_data), .tx_last(tx_last),
        .tx_ready(rdy1), .enc_en(en1), .enc_bit(bit1), .se0(se01), .busy(busy1),
        .underrun(ur1)
    );

    assign rdy_m  = sel ? rdy1 : rdy0;
    assign busy_m = sel ? busy1 : busy0;
    assign out_m  = sel ? {busy1, en1, bit1, se01, rdy1, ur1}
                        : {busy0, en0, bit0, se00, rdy0, ur0};

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d sel=%0d got{busy,en,bit,se0,rdy,ur}=%b exp=%b",
                     name, cyc, sel, got, exp);
        end
    endtask

    task automatic check_bound(input string name, input bit ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s cyc=%0d: wait bound expired (got timeout, exp event)", name, cyc);
        end
    endtask

    // Reference model: build the slot list from the line rules, then expand
    // each slot into CLKS_PER_BIT cycles. Slot fields {en,bit,se0,rdy,ur}.
    function automatic void model_push(input logic [7:0] pkt[$], input bit ur, input int cpb);
        logic [4:0] slots[$];
        logic [4:0] s;
        logic [7:0] sync_pat;
        logic [7:0] cur;
        logic       b;
        logic       lc;
        int ones;
        int nbits;
        sync_pat = 8'h80;
        ones = 0;
        nbits = 8 + 8 * pkt.size();
        for (int i = 0; i < nbits; i++) begin
            if (i >= 8 && (i % 8) == 0) begin
                s = slots[slots.size() - 1];
                s[1] = 1'b1;
                slots[slots.size() - 1] = s;
            end
            cur = (i < 8) ? sync_pat : pkt[i / 8 - 1];
            b = cur[3'(i % 8)];
            slots.push_back({1'b1, b, 3'b000});
            ones = b ? ones + 1 : 0;
            if (ones == 6) begin
                slots.push_back(5'b10000);
                ones = 0;
            end
        end
        if (ur) begin
            s = slots[slots.size() - 1];
            s[1] = 1'b1;
            s[0] = 1'b1;
            slots[slots.size() - 1] = s;
        end
        slots.push_back(5'b01100);
        slots.push_back(5'b01100);
        slots.push_back(5'b01000);
        exp_q.push_back(6'b001000);
        foreach (slots[k]) begin
            for (int c = 0; c < cpb; c++) begin
                lc = (c == cpb - 1);
                exp_q.push_back({1'b1, slots[k][4], slots[k][3], slots[k][2],
                                 slots[k][1] & lc, slots[k][0] & lc});
            end
        end
    endfunction

    // monitor / scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0) check("out_vec", out_m, exp_q.pop_front());
            else if (chk_idle) check("idle_vec", out_m, 6'b001000);
        end
    end

    // driver: called at posedge+#1, returns at posedge+#1 of the first IDLE cycle
    task automatic send_pkt(input logic [7:0] pkt[$], input bit ur);
        int n;
        int idx;
        int guard;
        n = pkt.size();
        idx = 0;
        guard = 0;
        model_push(pkt, ur, sel ? 4 : 1);
        tx_valid = 1'b1;
        tx_data  = (n > 0) ? pkt[0] : 8'($urandom);
        tx_last  = (n == 1) && !ur;
        if (n == 0) begin
            @(posedge clk); #1;
            tx_valid = 1'b0;
        end
        while (idx < n && guard < 4000) begin
            @(negedge clk);
            guard++;
            if (rdy_m) begin
                @(posedge clk); #1;
                idx++;
                if (idx < n) begin
                    tx_data = pkt[idx];
                    tx_last = (idx == n - 1) && !ur;
                end else begin
                    tx_valid = 1'b0;
                    tx_data  = 8'($urandom);
                    tx_last  = 1'($urandom);
                end
            end
        end
        if (n > 0) check_bound("handshake", idx == n);
        tx_valid = 1'b0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 4000) begin
            @(posedge clk);
            guard++;
        end
        check_bound("drain", exp_q.size() == 0);
        exp_q.delete();
        #1;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic random_pkt();
        int n;
        bit ur;
        ur = ($urandom_range(0, 3) == 0);
        n = ur ? $urandom_range(0, 3) : $urandom_range(1, 4);
        pq.delete();
        for (int i = 0; i < n; i++)
            pq.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
        send_pkt(pq, ur);
        gap();
    endtask

    task automatic reset_mid_sync();
        mon_en = 0;
        tx_valid = 1'b1;
        tx_data = 8'h3C;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (busy_m !== 1'b1) begin
            failures++;
            $display("FAIL busy_in_sync got=%b exp=1", busy_m);
        end
        RST = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_out", out_m, 6'b001000);
        @(posedge clk); #1;
        RST = 1'b0;
        mon_en = 1;
        chk_idle = 1;
        repeat (6) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        mon_en = 0;
        chk_idle = 0;
        sel = 1'b0;
        RST = 1'b1;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        tx_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_init", out_m, 6'b001000);
        @(posedge clk); #1;
        RST = 1'b0;
        mon_en = 1;
        chk_idle = 1;
        repeat (2) begin
            @(posedge clk); #1;
        end

        pq = '{8'h00};        send_pkt(pq, 1'b0);
        pq = '{8'hFF};        send_pkt(pq, 1'b0); gap();
        pq = '{8'hFC, 8'h01}; send_pkt(pq, 1'b0); gap();
        pq = '{8'hA5};        send_pkt(pq, 1'b1); gap();
        reset_mid_sync();
        for (int i = 0; i < 16; i++) random_pkt();

        sel = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        pq = '{8'h80};        send_pkt(pq, 1'b0); gap();
        pq = '{8'hFF, 8'hFF}; send_pkt(pq, 1'b0);
        for (int i = 0; i < 6; i++) random_pkt();

        repeat (4) begin
            @(posedge clk); #1;
        end
        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
